stream_xbar_sched: RTL

Credit-based, packet-aware grant scheduler for an N-input by M-output stream crossbar.
- For each output, picks one requesting input by round-robin.
- Holds that grant across multi-beat packets until the last beat.
- Gates every grant on a per-output downstream credit count.
- Sits beside the crossbar datapath: drives the per-input ready and per-output grant select. The crossbar only muxes data.

---
 rtl/stream_xbar_sched_pkg.sv | 18 +
 rtl/stream_xbar_sched_slot.sv | 114 +++++++++++
 rtl/stream_xbar_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/stream_xbar_sched_pkg.sv
// Shared types and width helpers for the stream crossbar grant scheduler.
package stream_xbar_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } slot_state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned log2up(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned credit_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/stream_xbar_sched_slot.sv
// Per-output scheduling slot: round-robin pick, packet lock, credit count, stall flag.
module stream_xbar_sched_slot
    import stream_xbar_sched_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned IN_WIDTH   = log2up(NUM_INPUTS),
    parameter int unsigned CREDITS    = 4,
    parameter int unsigned CREDIT_W   = credit_width(CREDITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] cand,
    input  logic [NUM_INPUTS-1:0] req_last,
    input  logic                  credit_return,
    output logic                  grant_valid_c,
    output logic [IN_WIDTH-1:0]   grant_idx_c,
    output logic                  stall_c,
    output logic [CREDIT_W-1:0]   credits,
    output logic                  locked,
    output logic [IN_WIDTH-1:0]   owner
);

    localparam logic [CREDIT_W-1:0] CREDITS_MAX = CREDIT_W'(CREDITS);
    localparam logic [IN_WIDTH-1:0] RR_RESET    = IN_WIDTH'(NUM_INPUTS - 1);

    slot_state_e         state_q, state_d;
    logic [IN_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IN_WIDTH-1:0] owner_q, owner_d;
    logic [IN_WIDTH-1:0] last_idx_q, last_idx_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;

    logic                win_found;
    logic [IN_WIDTH-1:0] win_idx;
    logic [IN_WIDTH-1:0] scan_idx;
    logic                has_credit;
    logic                grant;

    // Winner: the owner alone while locked, otherwise first candidate after rr_ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = owner_q;
        scan_idx  = '0;
        if (state_q == LOCKED) begin
            win_found = cand[owner_q];
        end else begin
            for (int unsigned i = 1; i <= NUM_INPUTS; i++) begin
                scan_idx = IN_WIDTH'((32'(rr_ptr_q) + i) % NUM_INPUTS);
                if (!win_found && cand[scan_idx]) begin
                    win_found = 1'b1;
                    win_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        has_credit    = (credits_q != '0);
        grant         = !reset && win_found && has_credit;
        stall_c       = !reset && win_found && !has_credit;
        grant_valid_c = grant;
        grant_idx_c   = grant ? win_idx : last_idx_q;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        last_idx_d = last_idx_q;
        credits_d  = credits_q;
        if (grant) begin
            last_idx_d = win_idx;
            if (state_q == IDLE) begin
                rr_ptr_d = win_idx;
                if (!req_last[win_idx]) begin
                    state_d = LOCKED;
                    owner_d = win_idx;
                end
            end else if (req_last[win_idx]) begin
                state_d = IDLE;
            end
        end
        // A simultaneous grant and return leaves the count unchanged.
        case ({grant, credit_return})
            2'b10:   credits_d = credits_q - CREDIT_W'(1);
            2'b01:   credits_d = (credits_q == CREDITS_MAX) ? credits_q : credits_q + CREDIT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= RR_RESET;
            owner_q    <= '0;
            last_idx_q <= '0;
            credits_q  <= CREDITS_MAX;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            last_idx_q <= last_idx_d;
            credits_q  <= credits_d;
        end
    end

    assign credits = credits_q;
    assign locked  = (state_q == LOCKED);
    assign owner   = owner_q;

    // Downstream may not return a slot that was never consumed.
    a_credit_overflow: assert property (@(posedge clk) disable iff (reset)
        !(credit_return && !grant && credits_q == CREDITS_MAX));

endmodule

// File: rtl/stream_xbar_sched.sv
// Credit-gated, packet-aware round-robin grant scheduler for an N x M stream crossbar.
module stream_xbar_sched
    import stream_xbar_sched_pkg::*;
#(
    parameter int unsigned NUM_INPUTS    = 4,
    parameter int unsigned NUM_OUTPUTS   = 4,
    parameter int unsigned IN_WIDTH      = log2up(NUM_INPUTS),
    parameter int unsigned OUT_WIDTH     = log2up(NUM_OUTPUTS),
    parameter int unsigned CREDITS       = 4,
    parameter int unsigned CREDIT_W      = credit_width(CREDITS),
    parameter int unsigned PERF_CTR_BITS = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_INPUTS-1:0]                  req_valid,
    input  logic [NUM_INPUTS-1:0][OUT_WIDTH-1:0]   req_sel,
    input  logic [NUM_INPUTS-1:0]                  req_last,
    output logic [NUM_INPUTS-1:0]                  req_ready,
    output logic [NUM_OUTPUTS-1:0]                 grant_valid,
    output logic [NUM_OUTPUTS-1:0][IN_WIDTH-1:0]   grant_idx,
    input  logic [NUM_OUTPUTS-1:0]                 credit_return,
    output logic [NUM_OUTPUTS-1:0][CREDIT_W-1:0]   credits,
    output logic [NUM_OUTPUTS-1:0]                 locked,
    output logic [PERF_CTR_BITS-1:0]               stalls
);

    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] cand;
    logic [NUM_OUTPUTS-1:0]                 stall_c;
    logic [NUM_OUTPUTS-1:0][IN_WIDTH-1:0]   owner;
    logic [PERF_CTR_BITS-1:0]               stalls_q, stalls_d;

    // Destination decode; a single-output crossbar ignores req_sel.
    always_comb begin
        cand = '0;
        for (int unsigned o = 0; o < NUM_OUTPUTS; o++) begin
            for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
                cand[o][j] = req_valid[j] && ((NUM_OUTPUTS == 1) || (req_sel[j] == OUT_WIDTH'(o)));
            end
        end
    end

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_slot
        stream_xbar_sched_slot #(
            .NUM_INPUTS (NUM_INPUTS),
            .IN_WIDTH   (IN_WIDTH),
            .CREDITS    (CREDITS),
            .CREDIT_W   (CREDIT_W)
        ) u_slot (
            .clk           (clk),
            .reset         (reset),
            .cand          (cand[o]),
            .req_last      (req_last),
            .credit_return (credit_return[o]),
            .grant_valid_c (grant_valid[o]),
            .grant_idx_c   (grant_idx[o]),
            .stall_c       (stall_c[o]),
            .credits       (credits[o]),
            .locked        (locked[o]),
            .owner         (owner[o])
        );
    end

    // An input is ready when the output it targets granted it this cycle.
    always_comb begin
        req_ready = '0;
        for (int unsigned o = 0; o < NUM_OUTPUTS; o++) begin
            for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
                if (cand[o][j] && grant_valid[o] && (grant_idx[o] == IN_WIDTH'(j))) begin
                    req_ready[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stalls_d = stalls_q + PERF_CTR_BITS'(|stall_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stalls_q <= '0;
        end else begin
            stalls_q <= stalls_d;
        end
    end

    assign stalls = stalls_q;

    for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_in_contract
        a_hold: assert property (@(posedge clk) disable iff (reset)
            (req_valid[j] && !req_ready[j]) |=>
                (req_valid[j] && $stable(req_sel[j]) && $stable(req_last[j])));
    end

    if (NUM_OUTPUTS > 1) begin : g_lock_contract
        for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
            a_owner_sel: assert property (@(posedge clk) disable iff (reset)
                (locked[o] && req_valid[owner[o]]) |-> (req_sel[owner[o]] == OUT_WIDTH'(o)));
        end
    end

endmodule
